// File: rtl/OoO_pkg.sv
// Shared core types: AXI4 read/write channel bundles and memory arbiter state encodings.
package OoO_pkg;

    typedef struct packed {
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic [31:0] rdata;
        logic        rlast;
        logic        rvalid;
    } axi_r_s2m_t;

    typedef struct packed {
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic awready;
        logic wready;
        logic bvalid;
    } axi_w_s2m_t;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} arb_r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} arb_w_state_e;
    typedef enum logic {REQ_IFU, REQ_LSU} arb_req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the last-served requester is held by the parent.
module rr_arb2
    import OoO_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_req_e   last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == REQ_LSU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 memory master between IFU refills and LSU accesses; keeps LSU reads
// and writes from overlapping so loads never pass stores.
module axi_mem_arbiter
    import OoO_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  axi_r_m2s_t ifu_r_req_i,
    output axi_r_s2m_t ifu_r_rsp_o,
    input  axi_r_m2s_t lsu_r_req_i,
    output axi_r_s2m_t lsu_r_rsp_o,
    input  axi_w_m2s_t lsu_w_req_i,
    output axi_w_s2m_t lsu_w_rsp_o,
    output axi_r_m2s_t mem_r_req_o,
    input  axi_r_s2m_t mem_r_rsp_i,
    output axi_w_m2s_t mem_w_req_o,
    input  axi_w_s2m_t mem_w_rsp_i
);

    arb_r_state_e r_state_q, r_state_d;
    arb_w_state_e w_state_q, w_state_d;
    arb_req_e     r_gnt_q, r_gnt_d;
    arb_req_e     last_gnt_q, last_gnt_d;
    logic         aw_done_q, aw_done_d;
    logic         w_done_q, w_done_d;

    logic         lsu_r_held;
    logic         lsu_w_accept;
    logic         aw_fire;
    logic         w_fire;
    logic [1:0]   arb_req;
    logic [1:0]   arb_gnt;
    axi_r_m2s_t   gnt_r_req;

    assign lsu_r_held   = (r_state_q != R_IDLE) && (r_gnt_q == REQ_LSU);
    assign lsu_w_accept = (w_state_q == W_IDLE) && lsu_w_req_i.awvalid && !lsu_r_held;

    // An LSU read only competes when no store is open or being opened this cycle.
    assign arb_req = {lsu_r_req_i.arvalid && (w_state_q == W_IDLE) && !lsu_w_accept,
                      ifu_r_req_i.arvalid};

    rr_arb2 u_rr_arb2 (
        .req_i  (arb_req),
        .last_i (last_gnt_q),
        .gnt_o  (arb_gnt)
    );

    assign gnt_r_req = (r_gnt_q == REQ_LSU) ? lsu_r_req_i : ifu_r_req_i;

    assign aw_fire = (w_state_q == W_XFER) && lsu_w_req_i.awvalid && !aw_done_q
                     && mem_w_rsp_i.awready;
    assign w_fire  = (w_state_q == W_XFER) && lsu_w_req_i.wvalid && !w_done_q
                     && mem_w_rsp_i.wready && lsu_w_req_i.wlast;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q  <= R_IDLE;
            r_gnt_q    <= REQ_IFU;
            last_gnt_q <= REQ_LSU;
            w_state_q  <= W_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_gnt_q    <= r_gnt_d;
            last_gnt_q <= last_gnt_d;
            w_state_q  <= w_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_gnt_d     = r_gnt_q;
        last_gnt_d  = last_gnt_q;
        mem_r_req_o = '0;
        ifu_r_rsp_o = '0;
        lsu_r_rsp_o = '0;
        ifu_r_rsp_o.rdata = mem_r_rsp_i.rdata;
        ifu_r_rsp_o.rlast = mem_r_rsp_i.rlast;
        lsu_r_rsp_o.rdata = mem_r_rsp_i.rdata;
        lsu_r_rsp_o.rlast = mem_r_rsp_i.rlast;

        unique case (r_state_q)
            R_IDLE: begin
                if (|arb_gnt) begin
                    r_gnt_d   = arb_gnt[1] ? REQ_LSU : REQ_IFU;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                mem_r_req_o        = gnt_r_req;
                mem_r_req_o.rready = 1'b0;
                if (r_gnt_q == REQ_LSU) lsu_r_rsp_o.arready = mem_r_rsp_i.arready;
                else                    ifu_r_rsp_o.arready = mem_r_rsp_i.arready;
                if (gnt_r_req.arvalid && mem_r_rsp_i.arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                mem_r_req_o.rready = gnt_r_req.rready;
                if (r_gnt_q == REQ_LSU) lsu_r_rsp_o.rvalid = mem_r_rsp_i.rvalid;
                else                    ifu_r_rsp_o.rvalid = mem_r_rsp_i.rvalid;
                if (mem_r_rsp_i.rvalid && gnt_r_req.rready && mem_r_rsp_i.rlast) begin
                    r_state_d  = R_IDLE;
                    last_gnt_d = r_gnt_q;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        mem_w_req_o = '0;
        lsu_w_rsp_o = '0;

        unique case (w_state_q)
            W_IDLE: begin
                if (lsu_w_accept) begin
                    w_state_d = W_XFER;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_XFER: begin
                // AW and W run independently; each is masked once its handshake is recorded.
                mem_w_req_o         = lsu_w_req_i;
                mem_w_req_o.awvalid = lsu_w_req_i.awvalid && !aw_done_q;
                mem_w_req_o.wvalid  = lsu_w_req_i.wvalid && !w_done_q;
                mem_w_req_o.bready  = 1'b0;
                lsu_w_rsp_o.awready = mem_w_rsp_i.awready && !aw_done_q;
                lsu_w_rsp_o.wready  = mem_w_rsp_i.wready && !w_done_q;
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                mem_w_req_o.bready = lsu_w_req_i.bready;
                lsu_w_rsp_o.bvalid = mem_w_rsp_i.bvalid;
                if (mem_w_rsp_i.bvalid && lsu_w_req_i.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

endmodule
